ram_arb_lat: RTL

- Parametrised on-chip memory model serving NUM_PORTS requesters (e.g. instruction fetch and LSU) through one shared array.
- Each port has independent valid/ready request and response handshakes.
- Requests are arbitrated round-robin and take a programmable access latency.
- Out-of-range addresses return an error response; the memory is never silently aliased.
- Used in place of the single-cycle fetch/data RAM when the core must tolerate variable memory latency.

---
 rtl/ram_arb_lat.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ram_arb_lat.sv
// Shared on-chip RAM model: round-robin arbitration over NUM_PORTS requesters,
// programmable access latency, one transaction in flight, error on out-of-range.
module ram_arb_lat #(
   parameter int unsigned           NUM_PORTS  = 2,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DEPTH_LOG2 = 12,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000,
   parameter int unsigned           LATENCY    = 1
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [NUM_PORTS-1:0]                req_valid,
   output logic [NUM_PORTS-1:0]                req_ready,
   input  logic [NUM_PORTS-1:0]                req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_wdata,
   input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] req_wmask,
   output logic [NUM_PORTS-1:0]                resp_valid,
   input  logic [NUM_PORTS-1:0]                resp_ready,
   output logic [DATA_WIDTH-1:0]               resp_rdata,
   output logic                                resp_err
);

   localparam int unsigned NB   = DATA_WIDTH / 8;
   localparam int unsigned OFFB = $clog2(NB);
   localparam int unsigned PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [63:0] SPAN = 64'(NB) << DEPTH_LOG2;
   localparam logic [PW:0] NP   = (PW+1)'(NUM_PORTS);
   localparam bit          LAT0 = (LATENCY == 0);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e                  state_q, state_d;
   logic [PW-1:0]           rr_q, rr_d, port_q, port_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    wr_q, wr_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [NB-1:0]           mask_q, mask_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    err_q, err_d;

   logic [DATA_WIDTH-1:0]   mem [(1 << DEPTH_LOG2)];

   logic                    gnt_any;
   logic [PW-1:0]           gnt_id;
   logic [PW:0]             cand;
   logic                    g_write;
   logic [ADDR_WIDTH-1:0]   g_addr;
   logic [DATA_WIDTH-1:0]   g_wdata;
   logic [NB-1:0]           g_mask;

   logic                    acc_fire, acc_write, acc_in;
   logic [ADDR_WIDTH-1:0]   acc_addr, acc_off;
   logic [DATA_WIDTH-1:0]   acc_wdata, old_word, merged;
   logic [NB-1:0]           acc_mask;
   logic [DEPTH_LOG2-1:0]   acc_idx;

   // Round-robin search starting at rr_q, wrapping modulo NUM_PORTS.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      cand    = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         cand = {1'b0, rr_q} + (PW+1)'(i);
         if (cand >= NP) cand = cand - NP;
         if (!gnt_any && req_valid[cand[PW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_id  = cand[PW-1:0];
         end
      end
      g_write = 1'b0;
      g_addr  = '0;
      g_wdata = '0;
      g_mask  = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if (gnt_id == PW'(p)) begin
            g_write = req_write[p];
            g_addr  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            g_wdata = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
            g_mask  = req_wmask[p*NB +: NB];
         end
      end
   end

   always_comb begin
      req_ready  = '0;
      resp_valid = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         req_ready[p]  = reset && (state_q == IDLE) && gnt_any && (gnt_id == PW'(p));
         resp_valid[p] = (state_q == RESP) && (port_q == PW'(p));
      end
   end

   // With zero latency the array is accessed straight from the granted request.
   assign acc_fire  = LAT0 ? (reset && (state_q == IDLE) && gnt_any)
                           : ((state_q == WAIT) && (cnt_q == 4'd1));
   assign acc_write = LAT0 ? g_write : wr_q;
   assign acc_addr  = LAT0 ? g_addr  : addr_q;
   assign acc_wdata = LAT0 ? g_wdata : wdata_q;
   assign acc_mask  = LAT0 ? g_mask  : mask_q;
   assign acc_off   = acc_addr - BASE_ADDR;
   assign acc_in    = 64'(acc_off) < SPAN;
   assign acc_idx   = acc_off[OFFB +: DEPTH_LOG2];
   assign old_word  = mem[acc_idx];

   always_comb begin
      merged = old_word;
      for (int unsigned b = 0; b < NB; b++) begin
         if (acc_mask[b]) merged[b*8 +: 8] = acc_wdata[b*8 +: 8];
      end
   end

   always_ff @(posedge clock) begin
      if (acc_fire && acc_write && acc_in) mem[acc_idx] <= merged;
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      port_d  = port_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mask_d  = mask_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               wr_d    = g_write;
               addr_d  = g_addr;
               wdata_d = g_wdata;
               mask_d  = g_mask;
               port_d  = gnt_id;
               rr_d    = (gnt_id == PW'(NUM_PORTS - 1)) ? '0 : gnt_id + 1'b1;
               if (LAT0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(LATENCY);
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = RESP;
         end
         RESP: begin
            if (|(resp_valid & resp_ready)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (acc_fire) begin
         rdata_d = (acc_in && !acc_write) ? old_word : '0;
         err_d   = !acc_in;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         rr_q    <= '0;
         cnt_q   <= '0;
         port_q  <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         port_q  <= port_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mask_q  <= mask_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule
